// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among NUM_REQ requesters.
// Optional completed-transaction counter is built when LOGIC_ARB_STATS_EN is defined.
module logic_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [3*NUM_REQ-1:0]       op,
  input  logic [DATA_W*NUM_REQ-1:0]  a,
  input  logic [DATA_W*NUM_REQ-1:0]  b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       res_valid,
  output logic [DATA_W-1:0]          res_data,
  output logic [ID_W-1:0]            res_id,
  output logic [2:0]                 res_op,
  input  logic                       res_ready
`ifdef LOGIC_ARB_STATS_EN
  ,
  input  logic                       cnt_clr,
  output logic [15:0]                done_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic [ID_W-1:0]     r_res_id;
  logic [2:0]          r_res_op;
  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic [ID_W-1:0]     w_idx;
  logic [2:0]          w_sel_op;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic                w_accept;
  logic [ID_W-1:0]     w_next_ptr;

  function automatic logic [DATA_W-1:0] gate_fn(input logic [2:0] f_op,
                                                input logic [DATA_W-1:0] f_a,
                                                input logic [DATA_W-1:0] f_b);
    logic [DATA_W-1:0] f_res;
    case (f_op)
      3'd0:    f_res = f_a & f_b;
      3'd1:    f_res = f_a | f_b;
      3'd2:    f_res = ~(f_a & f_b);
      3'd3:    f_res = ~(f_a | f_b);
      3'd4:    f_res = f_a ^ f_b;
      3'd5:    f_res = ~(f_a ^ f_b);
      3'd6:    f_res = ~f_a;
      3'd7:    f_res = ~f_b;
      default: f_res = '0;
    endcase
    return f_res;
  endfunction

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_op = op[3*i +: 3];
        w_sel_a  = a[DATA_W*i +: DATA_W];
        w_sel_b  = b[DATA_W*i +: DATA_W];
      end else begin
        w_sel_op = w_sel_op;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if ((r_state == S_IDLE) && w_found) begin
      gnt[w_winner] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  assign w_accept   = r_res_valid & res_ready;
  assign w_next_ptr = (r_res_id == ID_W'(NUM_REQ - 1)) ? '0 : r_res_id + ID_W'(1);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next_state = S_EXEC;
        else         w_next_state = S_IDLE;
      end
      S_EXEC:   w_next_state = S_RESULT;
      S_RESULT: begin
        if (w_accept) w_next_state = S_IDLE;
        else          w_next_state = S_RESULT;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // The pointer moves only when a result is consumed, so a stalled consumer cannot skew fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_op    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_res_id <= w_winner;
            r_res_op <= w_sel_op;
          end
        end
        S_EXEC: begin
          r_res_data  <= gate_fn(r_res_op, r_a, r_b);
          r_res_valid <= 1'b1;
        end
        S_RESULT: begin
          if (w_accept) begin
            r_res_valid <= 1'b0;
            r_rr_ptr    <= w_next_ptr;
          end
        end
        default: r_res_valid <= 1'b0;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_op    = r_res_op;

`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] r_done_cnt;

  // Clear has priority over a same-edge accept; the count saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= 16'd0;
    end else if (cnt_clr) begin
      r_done_cnt <= 16'd0;
    end else if (w_accept && (r_done_cnt != 16'hFFFF)) begin
      r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

  assign done_cnt = r_done_cnt;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: transaction-level model plus directed vectors.
// Define LOGIC_ARB_STATS_EN to also exercise the done counter.
module tb_logic_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic [2:0]  res_op;
  logic        res_ready;
`ifdef LOGIC_ARB_STATS_EN
  logic        cnt_clr;
  logic [15:0] done_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic_op_arbiter #(.NUM_REQ(4), .DATA_W(8), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_op(res_op), .res_ready(res_ready)
`ifdef LOGIC_ARB_STATS_EN
    , .cnt_clr(cnt_clr), .done_cnt(done_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out @%0t", nm, $time);
  endtask

  // Transaction-level reference: who wins, what the gate produces.
  function automatic int pick(input logic [3:0] r, input int p);
    logic [7:0] dbl;
    dbl = {r, r} >> p;
    for (int k = 0; k < 4; k++) if (dbl[k]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic logic [7:0] ref_fn(input int o, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] t;
    if (o < 4) begin
      t = (o % 2 == 0) ? (x & y) : (x | y);
      if (o >= 2) t = ~t;
    end else if (o < 6) begin
      t = x ^ y;
      if (o == 5) t = ~t;
    end else begin
      t = (o == 6) ? ~x : ~y;
    end
    return t;
  endfunction

  bit         m_busy;
  int         m_age;
  int         m_ptr;
  int         m_id;
  int         m_win;
  logic [2:0] m_op;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [15:0] m_cnt;

  always_comb m_win = pick(req, m_ptr);

  // m_age counts clock edges since the grant edge; a result is owed from age 2 on.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_ptr  <= 0;
      m_id   <= 0;
      m_op   <= 3'd0;
      m_cnt  <= 16'd0;
    end else begin
      if (!m_busy) begin
        if (req != 4'd0) begin
          m_busy <= 1'b1;
          m_age  <= 1;
          m_id   <= m_win;
          m_op   <= op[3*m_win +: 3];
          m_a    <= a[8*m_win +: 8];
          m_b    <= b[8*m_win +: 8];
        end
      end else if (m_age == 1) begin
        m_age <= 2;
      end else if (res_ready) begin
        m_busy <= 1'b0;
        m_ptr  <= (m_id + 1) % 4;
      end
`ifdef LOGIC_ARB_STATS_EN
      if (cnt_clr) m_cnt <= 16'd0;
      else if (m_busy && m_age == 2 && res_ready && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_gnt", gnt, (!m_busy && req != 4'd0) ? (32'd1 << m_win) : 32'd0);
      chk("m_busy", busy, m_busy);
      chk("m_valid", res_valid, (m_busy && m_age == 2) ? 32'd1 : 32'd0);
      if (m_busy) begin
        chk("m_res_id", res_id, m_id);
        chk("m_res_op", res_op, m_op);
      end
      if (m_busy && m_age == 2) chk("m_res_data", res_data, ref_fn(m_op, m_a, m_b));
`ifdef LOGIC_ARB_STATS_EN
      chk("m_done_cnt", done_cnt, m_cnt);
`endif
    end
  end

  task automatic set_req(input int id, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    op[3*id +: 3] = o;
    a[8*id +: 8]  = av;
    b[8*id +: 8]  = bv;
    req[id]       = 1'b1;
  endtask

  task automatic wait_gnt(input int id);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (gnt != 4'd0) begin
        seen = 1'b1;
        chk("gnt_sel", gnt, 32'd1 << id);
      end
    end
    if (!seen) fail("gnt_wait");
    @(posedge clk); #1;
    req[id] = 1'b0;
  endtask

  task automatic wait_res(output logic [7:0] d);
    int c = 0;
    bit seen = 1'b0;
    while (!seen && c < 50) begin
      @(negedge clk);
      c++;
      if (res_valid) seen = 1'b1;
    end
    if (!seen) fail("res_wait");
    chk("latency", c, 2);
    d = res_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] sweep_exp [8];
    int fair_exp [5];
    bit seen;
    sweep_exp[0] = 8'h05; sweep_exp[1] = 8'hAF; sweep_exp[2] = 8'hFA; sweep_exp[3] = 8'h50;
    sweep_exp[4] = 8'hAA; sweep_exp[5] = 8'h55; sweep_exp[6] = 8'h5A; sweep_exp[7] = 8'hF0;
    fair_exp[0] = 0; fair_exp[1] = 1; fair_exp[2] = 2; fair_exp[3] = 3; fair_exp[4] = 0;

    rst_n = 1'b0; req = 4'd0; op = 12'd0; a = 32'd0; b = 32'd0; res_ready = 1'b1;
`ifdef LOGIC_ARB_STATS_EN
    cnt_clr = 1'b0;
`endif
    @(negedge clk);
    chk("rst_gnt", gnt, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_valid", res_valid, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_id", res_id, 32'd0);
    chk("rst_op", res_op, 32'd0);
`ifdef LOGIC_ARB_STATS_EN
    chk("rst_cnt", done_cnt, 32'd0);
`endif
    #2 rst_n = 1'b1;

    // Single request, then pointer must sit at 1.
    @(posedge clk); #1;
    set_req(0, 3'd0, 8'hF0, 8'h3C);
    wait_gnt(0);
    wait_res(d);
    chk("single_data", d, 32'h30);
    chk("single_id", res_id, 32'd0);
    chk("single_op", res_op, 32'd0);
    set_req(1, 3'd1, 8'h11, 8'h22);
    set_req(0, 3'd0, 8'hF0, 8'h3C);
    wait_gnt(1);
    wait_res(d);
    chk("ptr1_data", d, 32'h33);
    wait_gnt(0);
    wait_res(d);
    chk("req0_data", d, 32'h30);

    // Opcode sweep on requester 2.
    for (int o = 0; o < 8; o++) begin
      set_req(2, 3'(o), 8'hA5, 8'h0F);
      wait_gnt(2);
      wait_res(d);
      chk("sweep_data", d, sweep_exp[o]);
      chk("sweep_id", res_id, 32'd2);
    end

    // Reset during EXEC drops the transaction.
    set_req(3, 3'd2, 8'hFF, 8'h0F);
    wait_gnt(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstx_valid", res_valid, 32'd0);
    chk("rstx_busy", busy, 32'd0);
    chk("rstx_gnt", gnt, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_ghost", res_valid, 32'd0);
    end
    set_req(3, 3'd6, 8'h3C, 8'h00);
    wait_gnt(3);
    wait_res(d);
    chk("after_rst_data", d, 32'hC3);
    chk("after_rst_id", res_id, 32'd3);

    // Fairness with all four requesting continuously.
    for (int i = 0; i < 4; i++) set_req(i, 3'd4, 8'h0F, 8'h00);
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (gnt != 4'd0) seen = 1'b1;
      end
      if (!seen) fail("fair_wait");
      chk("fair_onehot", $onehot(gnt), 32'd1);
      chk("fair_order", gnt, 32'd1 << fair_exp[g]);
    end
    @(posedge clk); #1;
    req = 4'd0;
    wait_res(d);
    @(posedge clk); #1;

    // Back-pressure: result held for ten cycles while requester 1 waits.
    res_ready = 1'b0;
    set_req(0, 3'd4, 8'h3C, 8'hFF);
    wait_gnt(0);
    set_req(1, 3'd0, 8'hFF, 8'hAA);
    wait_res(d);
    chk("bp_data0", d, 32'hC3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 32'd1);
      chk("bp_data", res_data, 32'hC3);
      chk("bp_id", res_id, 32'd0);
      chk("bp_gnt", gnt, 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_gnt", gnt, 32'h2);
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_res(d);
    chk("bp_req1_data", d, 32'hAA);

`ifdef LOGIC_ARB_STATS_EN
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int t = 0; t < 3; t++) begin
      set_req(0, 3'd1, 8'h01, 8'h02);
      wait_gnt(0);
      wait_res(d);
    end
    @(negedge clk);
    chk("cnt_three", done_cnt, 32'd3);
    set_req(0, 3'd1, 8'h01, 8'h02);
    wait_gnt(0);
    wait_res(d);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_wins", done_cnt, 32'd0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
